// File: rtl/rf_writeback_unit.sv
// RF write-port arbiter: ALU results win, LSU results queue in an in-order FIFO; tracks pending long-op destinations.
// One cycle ALU->wb_*, two cycles minimum LSU accept->wb_*; lsu_ready drops only when the FIFO is full.

// Generic synchronous FIFO, registered level, no pass-through.
// Push visible at the head one edge later; push ignored while full, pop ignored while empty.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop_vld,
  output logic [WIDTH-1:0]       pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int DEPTH_I = DEPTH;
  localparam logic [AW:0] FULL_LEVEL = DEPTH_I[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign do_push = push_vld & ~full;
  assign do_pop  = pop_vld & ~empty;
  assign pop_dat = mem[rd_ptr];

  // Storage needs no reset: level gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

module rf_writeback_unit #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [4:0]             alu_rd,
  input  logic [XLEN-1:0]        alu_data,
  input  logic                   lsu_valid,
  output logic                   lsu_ready,
  input  logic [4:0]             lsu_rd,
  input  logic [XLEN-1:0]        lsu_data,
  input  logic                   claim_valid,
  input  logic [4:0]             claim_rd,
  output logic [31:0]            busy_mask,
  output logic                   wb_we,
  output logic [4:0]             wb_rd,
  output logic [XLEN-1:0]        wb_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   err_waw
);
  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  wb_entry_t   push_ent;
  wb_entry_t   head_ent;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;
  logic        wb_from_lsu;
  logic [31:0] busy_nxt;

  assign lsu_ready = ~fifo_full;
  // x0 loads complete the handshake but never occupy a slot.
  assign fifo_push = lsu_valid & lsu_ready & (lsu_rd != 5'd0);
  assign fifo_pop  = ~alu_valid & ~fifo_empty;
  assign push_ent  = '{rd: lsu_rd, data: lsu_data};

  fifo #(
    .WIDTH($bits(wb_entry_t)),
    .DEPTH(DEPTH)
  ) u_lsu_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (fifo_push),
    .push_dat (push_ent),
    .pop_vld  (fifo_pop),
    .pop_dat  (head_ent),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we       <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      wb_from_lsu <= 1'b0;
    end else if (alu_valid) begin
      wb_we       <= (alu_rd != 5'd0);
      wb_from_lsu <= 1'b0;
      if (alu_rd != 5'd0) begin
        wb_rd   <= alu_rd;
        wb_data <= alu_data;
      end
    end else if (!fifo_empty) begin
      wb_we       <= 1'b1;
      wb_from_lsu <= 1'b1;
      wb_rd       <= head_ent.rd;
      wb_data     <= head_ent.data;
    end else begin
      wb_we       <= 1'b0;
      wb_from_lsu <= 1'b0;
    end
  end

  // Only queued long-op writes retire reservations; a same-edge claim overrides the clear.
  always_comb begin
    busy_nxt = busy_mask;
    if (wb_we && wb_from_lsu) busy_nxt[wb_rd] = 1'b0;
    if (claim_valid)          busy_nxt[claim_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_mask <= '0;
      err_waw   <= 1'b0;
    end else begin
      busy_mask <= busy_nxt;
      if (alu_valid && busy_mask[alu_rd]) err_waw <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rf_writeback_unit.sv
// Directed bench for rf_writeback_unit: each step drives inputs, advances one edge, checks outputs 1ns later.
module tb_rf_writeback_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic        claim_valid = 1'b0;
  logic [4:0]  claim_rd = '0;
  logic [31:0] busy_mask;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [2:0]  fifo_level;
  logic        err_waw;

  int checks = 0;
  int failures = 0;

  rf_writeback_unit #(.XLEN(32), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .claim_valid (claim_valid),
    .claim_rd    (claim_rd),
    .busy_mask   (busy_mask),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .fifo_level  (fifo_level),
    .err_waw     (err_waw)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] data);
    chk({tag, "_we"}, {31'd0, wb_we}, {31'd0, we});
    chk({tag, "_rd"}, {27'd0, wb_rd}, {27'd0, rd});
    chk({tag, "_data"}, wb_data, data);
  endtask

  task automatic chk_idle_reset(input string tag);
    chk_wb(tag, 1'b0, 5'd0, 32'd0);
    chk({tag, "_level"}, {29'd0, fifo_level}, 32'd0);
    chk({tag, "_ready"}, {31'd0, lsu_ready}, 32'd1);
    chk({tag, "_busy"}, busy_mask, 32'd0);
    chk({tag, "_err"}, {31'd0, err_waw}, 32'd0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk_idle_reset("rst_init");
    rst = 1'b0;

    // ALU path
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    chk_wb("alu_c1", 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    chk_wb("alu_c2", 1'b0, 5'd5, 32'hDEADBEEF);

    // ALU write to x0 is dropped
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    tick();
    alu_valid = 1'b0;
    chk("alu_x0_c1_we", {31'd0, wb_we}, 32'd0);
    tick();
    chk("alu_x0_c2_we", {31'd0, wb_we}, 32'd0);

    // Contention: ALU wins, LSU follows one cycle later
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h22;
    tick();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    chk_wb("cont_c1", 1'b1, 5'd3, 32'h11);
    chk("cont_c1_level", {29'd0, fifo_level}, 32'd1);
    tick();
    chk_wb("cont_c2", 1'b1, 5'd4, 32'h22);
    chk("cont_c2_level", {29'd0, fifo_level}, 32'd0);
    tick();
    chk("cont_c3_we", {31'd0, wb_we}, 32'd0);

    // Continuous ALU for 4 cycles holds the queued load
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd3 + 5'(i); alu_data = 32'h60 + i;
      tick();
      lsu_valid = 1'b0;
      chk_wb("stream_alu", 1'b1, 5'd3 + 5'(i), 32'h60 + i);
      chk("stream_level", {29'd0, fifo_level}, 32'd1);
    end
    alu_valid = 1'b0;
    tick();
    chk_wb("stream_gap", 1'b1, 5'd4, 32'h22);
    chk("stream_gap_level", {29'd0, fifo_level}, 32'd0);

    // x0 load handshakes but is not queued
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h55;
    chk("lsu_x0_ready", {31'd0, lsu_ready}, 32'd1);
    tick();
    lsu_valid = 1'b0;
    chk("lsu_x0_level", {29'd0, fifo_level}, 32'd0);
    tick();
    chk("lsu_x0_we", {31'd0, wb_we}, 32'd0);

    // FIFO full with ALU busy, 5th offer held, then drain in order
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    for (int i = 0; i < 4; i++) begin
      lsu_valid = 1'b1; lsu_rd = 5'd8 + 5'(i); lsu_data = 32'hA0 + i;
      tick();
      chk("fill_level", {29'd0, fifo_level}, 32'(i + 1));
    end
    chk("full_ready", {31'd0, lsu_ready}, 32'd0);
    lsu_rd = 5'd12; lsu_data = 32'hA4;
    tick();
    chk("full_hold_level", {29'd0, fifo_level}, 32'd4);
    chk("full_hold_ready", {31'd0, lsu_ready}, 32'd0);
    alu_valid = 1'b0;
    tick();
    chk_wb("drain0", 1'b1, 5'd8, 32'hA0);
    chk("drain0_level", {29'd0, fifo_level}, 32'd3);
    chk("drain0_ready", {31'd0, lsu_ready}, 32'd1);
    tick();
    lsu_valid = 1'b0;
    chk_wb("drain1", 1'b1, 5'd9, 32'hA1);
    chk("drain1_level", {29'd0, fifo_level}, 32'd3);
    for (int i = 2; i < 5; i++) begin
      tick();
      chk_wb("drain_n", 1'b1, 5'd8 + 5'(i), 32'hA0 + i);
    end
    chk("drained_level", {29'd0, fifo_level}, 32'd0);
    tick();
    chk("drained_we", {31'd0, wb_we}, 32'd0);

    // Scoreboard: claim x7, retire via load
    claim_valid = 1'b1; claim_rd = 5'd7;
    tick();
    claim_valid = 1'b0;
    chk("sb_claim", busy_mask, 32'h80);
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
    tick();
    lsu_valid = 1'b0;
    chk("sb_push_busy", busy_mask, 32'h80);
    tick();
    chk_wb("sb_wb", 1'b1, 5'd7, 32'h77);
    chk("sb_wb_busy", busy_mask, 32'h80);
    tick();
    chk("sb_cleared", busy_mask, 32'h0);

    // Claim x0 ignored; claim and clear of x7 on the same edge
    claim_valid = 1'b1; claim_rd = 5'd0;
    tick();
    chk("sb_claim_x0", busy_mask, 32'h0);
    claim_rd = 5'd7;
    tick();
    claim_valid = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h78;
    tick();
    lsu_valid = 1'b0;
    tick();
    chk_wb("sb2_wb", 1'b1, 5'd7, 32'h78);
    claim_valid = 1'b1; claim_rd = 5'd7;
    tick();
    claim_valid = 1'b0;
    chk("sb2_claim_wins", busy_mask, 32'h80);
    tick();
    chk("sb2_still_set", busy_mask, 32'h80);
    chk("sb2_err", {31'd0, err_waw}, 32'd0);

    // WAW: ALU writes a reserved register
    claim_valid = 1'b1; claim_rd = 5'd9;
    tick();
    claim_valid = 1'b0;
    chk("waw_busy", busy_mask, 32'h280);
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    tick();
    alu_valid = 1'b0;
    chk_wb("waw_wb", 1'b1, 5'd9, 32'h99);
    chk("waw_err", {31'd0, err_waw}, 32'd1);
    tick(); tick();
    chk("waw_busy_kept", busy_mask, 32'h280);
    chk("waw_err_sticky", {31'd0, err_waw}, 32'd1);

    // Mid-stream reset with 3 queued entries
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    for (int i = 0; i < 3; i++) begin
      lsu_valid = 1'b1; lsu_rd = 5'd20 + 5'(i); lsu_data = 32'hC0 + i;
      tick();
    end
    chk("pre_rst_level", {29'd0, fifo_level}, 32'd3);
    rst = 1'b1;
    alu_valid = 1'b0; lsu_valid = 1'b0;
    #2;
    chk_idle_reset("rst_async");
    tick();
    rst = 1'b0;
    tick();
    chk_idle_reset("rst_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
